mat_mul_seq: RTL and testbench

Matrix-multiply sequencer that sits directly downstream of the two operand registers (matrix A and matrix B, 16 × 32-bit, row-major). On a start pulse it walks both operand registers through their read ports, multiply-accumulates C[i][j] = Σk A[i][k]·B[k][j] for a 4×4 product, and writes each result element to the result register through a write port. It owns the operand read addresses for the whole run, and it is the only writer of C.

---
 rtl/mat_mul_seq_pkg.sv | 25 ++
 rtl/mat_mul_seq_if.sv | 23 ++
 rtl/mat_mul_seq_mac.sv | 50 +++++
 rtl/mat_mul_seq.sv | 149 ++++++++++++++
 tb/tb_mat_mul_seq.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_mul_seq_pkg.sv
// Shared constants, sequencer state type and row-major address helper
// for the matrix-multiply sequencer.
package mat_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 4;
  localparam int MATRIX_DIM  = 4;
  localparam int MATRIX_SIZE = MATRIX_DIM * MATRIX_DIM;
  localparam int DIM_W       = $clog2(MATRIX_DIM);
  // Phase counter spans t = 0..MATRIX_DIM, one more than the number of terms.
  localparam int PHASE_W     = $clog2(MATRIX_DIM + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [ADDR_W-1:0] idx(input logic [DIM_W-1:0] row,
                                            input logic [DIM_W-1:0] col);
    return ADDR_W'(int'(row) * MATRIX_DIM + int'(col));
  endfunction

endpackage

// File: rtl/mat_mul_seq_if.sv
// Operand read ports (A, B) and result write port (C) seen by the sequencer.
interface mat_mul_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] addr_A_o;
  logic [DATA_WIDTH-1:0] read_data_A_i;
  logic [ADDR_WIDTH-1:0] addr_B_o;
  logic [DATA_WIDTH-1:0] read_data_B_i;
  logic [ADDR_WIDTH-1:0] addr_C_o;
  logic [DATA_WIDTH-1:0] write_data_C_o;
  logic                  write_en_C_o;

  modport master (
    output addr_A_o, addr_B_o, addr_C_o, write_data_C_o, write_en_C_o,
    input  read_data_A_i, read_data_B_i
  );

  modport slave (
    input  addr_A_o, addr_B_o, addr_C_o, write_data_C_o, write_en_C_o,
    output read_data_A_i, read_data_B_i
  );
endinterface

// File: rtl/mat_mul_seq_mac.sv
// Signed multiply-accumulate datapath: one registered product stage feeding
// a 2*DATA_WIDTH+2 accumulator.
module mat_mac #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  input  logic                          capture_i,
  input  logic                          accumulate_i,
  input  logic        [DATA_WIDTH-1:0]  a_i,
  input  logic        [DATA_WIDTH-1:0]  b_i,
  output logic signed [2*DATA_WIDTH+1:0] acc_o
);
  localparam int PROD_W = 2 * DATA_WIDTH;
  localparam int ACC_W  = 2 * DATA_WIDTH + 2;

  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;

  always_comb begin
    prod_d = prod_q;
    if (capture_i) begin
      prod_d = PROD_W'($signed(a_i)) * PROD_W'($signed(b_i));
    end
  end

  // Clear wins so the first phase never folds in a product left from the last element.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (accumulate_i) begin
      acc_d = acc_q + ACC_W'(prod_q);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q <= '0;
      acc_q  <= '0;
    end else begin
      prod_q <= prod_d;
      acc_q  <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/mat_mul_seq.sv
// 4x4 signed matrix-multiply sequencer: walks the A/B read ports, accumulates
// each C element over MATRIX_DIM+1 phases and writes it through the C port.
module mat_mul_seq
  import mat_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          ovf_o,
  mat_mul_seq_if.master bus
);
  // state | meaning
  // IDLE  | waiting for start_i
  // RUN   | MAC phases t = 0..MATRIX_DIM for element (i,j)
  // WRITE | drive C[i][j], fold overflow into the sticky flag, advance (i,j)
  // DONE  | one-cycle completion pulse

  localparam int                 ACC_W      = 2 * DATA_WIDTH + 2;
  localparam logic [DIM_W-1:0]   LAST_IDX   = DIM_W'(MATRIX_DIM - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(MATRIX_DIM);

  state_e               state_q, state_d;
  logic [DIM_W-1:0]     i_q, i_d;
  logic [DIM_W-1:0]     j_q, j_d;
  logic [PHASE_W-1:0]   t_q, t_d;
  logic                 ovf_q, ovf_d;

  logic                 mac_clear, mac_capture, mac_accumulate;
  logic signed [ACC_W-1:0] acc;
  logic                 acc_ovf;
  logic [DIM_W-1:0]     k;

  assign k = t_q[DIM_W-1:0];

  // In range only if every bit from the result sign bit upward agrees.
  assign acc_ovf = !((&acc[ACC_W-1:DATA_WIDTH-1]) || !(|acc[ACC_W-1:DATA_WIDTH-1]));

  mat_mac #(.DATA_WIDTH(DATA_WIDTH)) u_mac (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (mac_clear),
    .capture_i    (mac_capture),
    .accumulate_i (mac_accumulate),
    .a_i          (bus.read_data_A_i),
    .b_i          (bus.read_data_B_i),
    .acc_o        (acc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      t_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      t_q     <= t_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    t_d     = t_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          i_d     = '0;
          j_d     = '0;
          t_d     = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (t_q == LAST_PHASE) begin
          state_d = WRITE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      WRITE: begin
        ovf_d = ovf_q | acc_ovf;
        if (i_q == LAST_IDX && j_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
          if (j_q == LAST_IDX) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o             = 1'b0;
    done_o             = 1'b0;
    ovf_o              = ovf_q;
    bus.addr_A_o       = '0;
    bus.addr_B_o       = '0;
    bus.addr_C_o       = '0;
    bus.write_data_C_o = '0;
    bus.write_en_C_o   = 1'b0;
    mac_clear          = 1'b0;
    mac_capture        = 1'b0;
    mac_accumulate     = 1'b0;
    case (state_q)
      RUN: begin
        busy_o         = 1'b1;
        mac_clear      = (t_q == '0);
        mac_capture    = (t_q != LAST_PHASE);
        mac_accumulate = (t_q != '0);
        if (t_q != LAST_PHASE) begin
          bus.addr_A_o = ADDR_WIDTH'(idx(i_q, k));
          bus.addr_B_o = ADDR_WIDTH'(idx(k, j_q));
        end
      end
      WRITE: begin
        busy_o             = 1'b1;
        bus.write_en_C_o   = 1'b1;
        bus.addr_C_o       = ADDR_WIDTH'(idx(i_q, j_q));
        bus.write_data_C_o = acc[DATA_WIDTH-1:0];
        // Flag is visible in the write cycle itself, not one cycle later.
        ovf_o              = ovf_q | acc_ovf;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mat_mul_seq.sv
// Self-checking bench for mat_mul_seq: directed table, random runs against a
// plain-arithmetic matrix model, plus start/reset/back-to-back sequences.
module tb_mat_mul_seq;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, ovf;

  mat_mul_seq_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [31:0] mem_c [16];

  assign bus.read_data_A_i = mem_a[bus.addr_A_o];
  assign bus.read_data_B_i = mem_b[bus.addr_B_o];

  mat_mul_seq dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .busy_o  (busy),
    .done_o  (done),
    .ovf_o   (ovf),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] exp_c [16];
  int          exp_ovf_cyc;

  int          wr_cnt, done_cnt, done_cyc, busy_cnt, ovf_first, last_wr;
  int          wr_cyc  [16];
  logic [3:0]  wr_addr [16];
  logic        ovf_at_done, ovf_c1, busy99;

  typedef struct {
    string       name;
    int          a_mode;   // 0 fill, 1 identity, 2 only element 0
    logic [31:0] a_val;
    int          b_mode;   // 0 fill, 1 ramp n+1, 2 only element 0
    logic [31:0] b_val;
    int          e_mode;   // 0 constant, 1 ramp n+1, 2 only element 0
    logic [31:0] e_val;
    int          e_ovf_cyc;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, done, ovf, bus.addr_A_o, bus.addr_B_o, bus.addr_C_o,
                bus.write_data_C_o, bus.write_en_C_o});
  endfunction

  task automatic model();
    logic signed [65:0] s, ea, eb;
    exp_ovf_cyc = -1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        s = '0;
        for (int k = 0; k < 4; k++) begin
          ea = 66'($signed(mem_a[i*4+k]));
          eb = 66'($signed(mem_b[k*4+j]));
          s  = s + ea * eb;
        end
        exp_c[i*4+j] = s[31:0];
        if ((s > 66'sd2147483647 || s < -66'sd2147483648) && exp_ovf_cyc < 0)
          exp_ovf_cyc = 6 * (i*4+j) + 6;
      end
    end
  endtask

  task automatic clear_c();
    for (int n = 0; n < 16; n++) mem_c[n] = 32'hDEAD_BEEF;
  endtask

  task automatic run(input int pulse_cyc, input int rst_cyc, input bit hold);
    int last;
    last        = hold ? 99 : 98;
    wr_cnt      = 0;
    done_cnt    = 0;
    done_cyc    = -1;
    busy_cnt    = 0;
    ovf_first   = -1;
    ovf_at_done = 1'b0;
    ovf_c1      = 1'b1;
    last_wr     = -1;
    busy99      = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      if (c <= 98 && busy) busy_cnt++;
      if (c == 99) busy99 = busy;
      if (c == 1) ovf_c1 = ovf;
      if (ovf && ovf_first < 0 && c <= 97) ovf_first = c;
      if (done && c <= 98) begin
        done_cnt++;
        done_cyc    = c;
        ovf_at_done = ovf;
      end
      if (bus.write_en_C_o && c <= 98) begin
        if (wr_cnt < 16) begin
          wr_cyc[wr_cnt]  = c;
          wr_addr[wr_cnt] = bus.addr_C_o;
        end
        wr_cnt++;
        last_wr = c;
        mem_c[bus.addr_C_o] = bus.write_data_C_o;
      end
      start = hold || (c == pulse_cyc);
      if (c == rst_cyc) begin
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", out_vec(), 64'd0);
        break;
      end
    end
    if (!hold) start = 1'b0;
  endtask

  task automatic check_run(input string tag);
    for (int n = 0; n < 16; n++) begin
      chk($sformatf("%s c_data[%0d]", tag, n), 64'(mem_c[n]), 64'(exp_c[n]));
      chk($sformatf("%s wr_slot[%0d]", tag, n), 64'({wr_cyc[n], wr_addr[n]}),
          64'({32'(6*n+6), 4'(n)}));
    end
    chk({tag, " wr_count"},  64'(wr_cnt),   64'd16);
    chk({tag, " done_count"}, 64'(done_cnt), 64'd1);
    chk({tag, " done_cycle"}, 64'(done_cyc), 64'd97);
    chk({tag, " busy_cycles"}, 64'(busy_cnt), 64'd96);
    chk({tag, " ovf_at_done"}, 64'(ovf_at_done), 64'(exp_ovf_cyc >= 0));
    chk({tag, " ovf_rise_cycle"}, 64'(ovf_first), 64'(exp_ovf_cyc));
    chk({tag, " ovf_cleared"}, 64'(ovf_c1), 64'd0);
  endtask

  initial begin
    tbl[0] = '{"identity", 1, 32'd0, 1, 32'd0, 1, 32'd0, -1};
    tbl[1] = '{"overflow", 2, 32'h7FFF_FFFF, 2, 32'h7FFF_FFFF, 2, 32'h0000_0001, 6};
    tbl[2] = '{"const",    0, 32'd2, 0, 32'd3, 0, 32'd24, -1};
    tbl[3] = '{"signed",   0, 32'hFFFF_FFFF, 0, 32'd5, 0, 32'hFFFF_FFEC, -1};

    rst   = 1'b1;
    start = 1'b0;
    for (int n = 0; n < 16; n++) begin
      mem_a[n] = '0;
      mem_b[n] = '0;
    end
    clear_c();
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", out_vec(), 64'd0);

    for (int v = 0; v < 4; v++) begin
      for (int n = 0; n < 16; n++) begin
        case (tbl[v].a_mode)
          0:       mem_a[n] = tbl[v].a_val;
          1:       mem_a[n] = (n / 4 == n % 4) ? 32'd1 : 32'd0;
          default: mem_a[n] = (n == 0) ? tbl[v].a_val : 32'd0;
        endcase
        case (tbl[v].b_mode)
          0:       mem_b[n] = tbl[v].b_val;
          1:       mem_b[n] = 32'(n + 1);
          default: mem_b[n] = (n == 0) ? tbl[v].b_val : 32'd0;
        endcase
        case (tbl[v].e_mode)
          0:       exp_c[n] = tbl[v].e_val;
          1:       exp_c[n] = 32'(n + 1);
          default: exp_c[n] = (n == 0) ? tbl[v].e_val : 32'd0;
        endcase
      end
      exp_ovf_cyc = tbl[v].e_ovf_cyc;
      clear_c();
      run(-1, -1, 1'b0);
      check_run(tbl[v].name);
    end

    // Randomized runs: small-range values, then full 32-bit range.
    for (int r = 0; r < 4; r++) begin
      for (int n = 0; n < 16; n++) begin
        if (r < 2) begin
          mem_a[n] = 32'($signed($urandom_range(2000)) - 1000);
          mem_b[n] = 32'($signed($urandom_range(2000)) - 1000);
        end else begin
          mem_a[n] = $urandom;
          mem_b[n] = $urandom;
        end
      end
      model();
      clear_c();
      // One of the runs also gets a stray start pulse mid-run, which must be ignored.
      run((r == 1) ? 40 : -1, -1, 1'b0);
      check_run($sformatf("random%0d", r));
    end

    // Reset asserted in cycle 50 aborts the run after the write in cycle 48.
    for (int n = 0; n < 16; n++) begin
      mem_a[n] = $urandom;
      mem_b[n] = $urandom;
    end
    mem_a[0] = 32'h7FFF_FFFF;
    mem_b[0] = 32'h7FFF_FFFF;
    model();
    clear_c();
    run(-1, 50, 1'b0);
    chk("rst wr_count", 64'(wr_cnt), 64'd8);
    chk("rst last_write_cycle", 64'(last_wr), 64'd48);
    chk("rst partial c[7]", 64'(mem_c[7]), 64'(exp_c[7]));
    chk("rst untouched c[8]", 64'(mem_c[8]), 64'h0000_0000_DEAD_BEEF);
    repeat (2) @(negedge clk);
    chk("rst held outputs", out_vec(), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    clear_c();
    run(-1, -1, 1'b0);
    check_run("after_reset");

    // start_i held high: the IDLE cycle 98 must accept a new run.
    for (int n = 0; n < 16; n++) begin
      mem_a[n] = 32'($signed($urandom_range(200)) - 100);
      mem_b[n] = 32'($signed($urandom_range(200)) - 100);
    end
    model();
    clear_c();
    run(-1, -1, 1'b1);
    check_run("held_start");
    chk("held_start busy_at_99", 64'(busy99), 64'd1);
    start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 150 && !seen; c++) begin
        @(negedge clk);
        if (done) seen = 1'b1;
      end
      chk("second_run_done_seen", 64'(seen), 64'd1);
    end
    @(negedge clk);
    chk("final_idle_outputs", 64'({busy, done}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
